wb_ram_arbiter: RTL and testbench

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

---
 rtl/wb_arb_pkg.sv | 64 ++++++
 rtl/wb_ram_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone RAM arbiter.
// Holds the FSM state type, the master index constants, the default
// slave-ack wait limit and the round-robin winner selection function.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0] M_IBUS = 2'd0;
    localparam logic [1:0] M_DBUS = 2'd1;
    localparam logic [1:0] M_DM   = 2'd2;
    localparam logic [1:0] M_NONE = 2'd3;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

    // Next master index in the fixed cyclic order 0 -> 1 -> 2 -> 0.
    // M_NONE also maps to master 0 so a corrupted index still recovers.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        if (idx >= M_DM) begin
            nxt = M_IBUS;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

    // Request bit for one master index; M_NONE never requests.
    function automatic logic rr_req(input logic [2:0] req, input logic [1:0] idx);
        logic hit;
        case (idx)
            M_IBUS:  hit = req[0];
            M_DBUS:  hit = req[1];
            M_DM:    hit = req[2];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Round-robin winner: search starts at the master after 'last'.
    // Returns M_NONE when nobody requests.
    function automatic logic [1:0] rr_select(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] c3;
        logic [1:0] win;
        c1 = rr_next(last);
        c2 = rr_next(c1);
        c3 = rr_next(c2);
        if (rr_req(req, c1)) begin
            win = c1;
        end else if (rr_req(req, c2)) begin
            win = c2;
        end else if (rr_req(req, c3)) begin
            win = c3;
        end else begin
            win = M_NONE;
        end
        return win;
    endfunction

endpackage

// File: rtl/wb_ram_arbiter.sv
// Three-master Wishbone arbiter in front of a single shared RAM slave.
// Masters: m0 = CPU instruction bus (read-only), m1 = CPU data bus,
// m2 = debug-module system bus. One transaction at a time, round-robin
// between transactions, with a slave-ack watchdog.
// Ports:
//   i_wb_clk / i_wb_rst      clock, asynchronous active-high reset
//   i_m0_* / o_m0_*          master 0 address/cyc in, read data/ack out
//   i_m1_* / o_m1_*          master 1 full request in, read data/ack out
//   i_m2_* / o_m2_*          master 2 full request in, read data/ack out
//   o_s_* / i_s_*            shared slave request out, read data/ack in
//   o_grant                  owning master index, 2'd3 when idle
//   o_timeout_err            one-cycle pulse when the watchdog fires
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_RDT = 32'h0000_0000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [31:0] i_m0_adr,
    input  logic        i_m0_cyc,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    input  logic [31:0] i_m2_adr,
    input  logic [31:0] i_m2_dat,
    input  logic [3:0]  i_m2_sel,
    input  logic        i_m2_we,
    input  logic        i_m2_cyc,
    output logic [31:0] o_m2_rdt,
    output logic        o_m2_ack,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout_err
);

    // Counter value on which the watchdog fires (BUSY cycle number TIMEOUT).
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

    arb_state_e  state_r;
    arb_state_e  state_nxt_s;
    logic [1:0]  grant_r;
    logic [1:0]  grant_nxt_s;
    logic [1:0]  last_grant_r;
    logic [1:0]  last_grant_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nxt_s;
    logic [2:0]  req_s;
    logic [31:0] g_adr_s;
    logic [31:0] g_dat_s;
    logic [3:0]  g_sel_s;
    logic        g_we_s;
    logic        g_cyc_s;
    logic        ack_s;
    logic [31:0] ack_rdt_s;

    assign req_s = {i_m2_cyc, i_m1_cyc, i_m0_cyc};

    // Request fields of the currently granted master; m0 is a fixed full-word read.
    always_comb begin
        g_adr_s = 32'h0000_0000;
        g_dat_s = 32'h0000_0000;
        g_sel_s = 4'h0;
        g_we_s  = 1'b0;
        g_cyc_s = 1'b0;
        case (grant_r)
            M_IBUS: begin
                g_adr_s = i_m0_adr;
                g_sel_s = 4'hF;
                g_cyc_s = i_m0_cyc;
            end
            M_DBUS: begin
                g_adr_s = i_m1_adr;
                g_dat_s = i_m1_dat;
                g_sel_s = i_m1_sel;
                g_we_s  = i_m1_we;
                g_cyc_s = i_m1_cyc;
            end
            M_DM: begin
                g_adr_s = i_m2_adr;
                g_dat_s = i_m2_dat;
                g_sel_s = i_m2_sel;
                g_we_s  = i_m2_we;
                g_cyc_s = i_m2_cyc;
            end
            default: begin
                g_cyc_s = 1'b0;
            end
        endcase
    end

    // FSM next state, slave-side outputs and the completion (ack/timeout) decision.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        wait_cnt_nxt_s   = wait_cnt_r;
        o_s_adr          = 32'h0000_0000;
        o_s_dat          = 32'h0000_0000;
        o_s_sel          = 4'h0;
        o_s_we           = 1'b0;
        o_s_cyc          = 1'b0;
        o_grant          = M_NONE;
        o_timeout_err    = 1'b0;
        ack_s            = 1'b0;
        ack_rdt_s        = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (req_s != 3'b000) begin
                    grant_nxt_s    = rr_select(last_grant_r, req_s);
                    wait_cnt_nxt_s = 8'd0;
                    state_nxt_s    = ST_BUSY;
                end else begin
                    grant_nxt_s = M_NONE;
                end
            end
            ST_BUSY: begin
                o_grant = grant_r;
                if (!g_cyc_s) begin
                    // Master gave up: drop the slave cycle now, no ack.
                    state_nxt_s      = ST_IDLE;
                    grant_nxt_s      = M_NONE;
                    last_grant_nxt_s = grant_r;
                end else begin
                    o_s_cyc = 1'b1;
                    o_s_adr = g_adr_s;
                    o_s_dat = g_dat_s;
                    o_s_sel = g_sel_s;
                    o_s_we  = g_we_s;
                    if (i_s_ack) begin
                        // A real ack wins over a simultaneous timeout.
                        ack_s            = 1'b1;
                        ack_rdt_s        = i_s_rdt;
                        state_nxt_s      = ST_IDLE;
                        grant_nxt_s      = M_NONE;
                        last_grant_nxt_s = grant_r;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        ack_s            = 1'b1;
                        ack_rdt_s        = ERR_RDT;
                        o_timeout_err    = 1'b1;
                        state_nxt_s      = ST_IDLE;
                        grant_nxt_s      = M_NONE;
                        last_grant_nxt_s = grant_r;
                    end else if (wait_cnt_r != 8'hFF) begin
                        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = M_NONE;
            end
        endcase
    end

    // Route the single ack/read-data pair to the granted master only.
    always_comb begin
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        o_m2_ack = 1'b0;
        o_m0_rdt = 32'h0000_0000;
        o_m1_rdt = 32'h0000_0000;
        o_m2_rdt = 32'h0000_0000;
        if (ack_s) begin
            case (grant_r)
                M_IBUS: begin
                    o_m0_ack = 1'b1;
                    o_m0_rdt = ack_rdt_s;
                end
                M_DBUS: begin
                    o_m1_ack = 1'b1;
                    o_m1_rdt = ack_rdt_s;
                end
                M_DM: begin
                    o_m2_ack = 1'b1;
                    o_m2_rdt = ack_rdt_s;
                end
                default: begin
                    o_m0_ack = 1'b0;
                end
            endcase
        end else begin
            o_m0_ack = 1'b0;
        end
    end

    // State, grant, last-grant and wait-counter registers; last_grant resets to m2 so m0 wins first.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= M_NONE;
            last_grant_r <= M_DM;
            wait_cnt_r   <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            wait_cnt_r   <= wait_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: the stimulus pushes the expected
// transaction (winner, slave request, completion) into a queue, and a
// negedge monitor pops/compares whenever the slave cycle starts or ends.
module tb_wb_ram_arbiter;

    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'h0000_0000;
    localparam int          NEVER = 255;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] rdt;
        logic        tmo;
        int          cyc_idx;
        logic        abort;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_adr [3];
    logic [31:0] m_dat [3];
    logic [3:0]  m_sel [3];
    logic        m_we  [3];
    logic [2:0]  m_cyc = 3'b000;
    logic [31:0] o_m0_rdt, o_m1_rdt, o_m2_rdt;
    logic        o_m0_ack, o_m1_ack, o_m2_ack;
    logic [31:0] o_s_adr, o_s_dat, i_s_rdt;
    logic [3:0]  o_s_sel;
    logic        o_s_we, o_s_cyc, i_s_ack;
    logic [1:0]  o_grant;
    logic        o_timeout_err;

    int   total = 0;
    int   bad = 0;
    int   slave_lat = 0;
    logic stray = 1'b0;
    logic [7:0] s_cnt;
    int   model_last = 2;
    exp_t sb [$];

    wb_ram_arbiter #(.TIMEOUT(TMO), .ERR_RDT(ERR)) dut (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_m0_adr(m_adr[0]), .i_m0_cyc(m_cyc[0]), .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack),
        .i_m1_adr(m_adr[1]), .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]), .i_m1_we(m_we[1]),
        .i_m1_cyc(m_cyc[1]), .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack),
        .i_m2_adr(m_adr[2]), .i_m2_dat(m_dat[2]), .i_m2_sel(m_sel[2]), .i_m2_we(m_we[2]),
        .i_m2_cyc(m_cyc[2]), .o_m2_rdt(o_m2_rdt), .o_m2_ack(o_m2_ack),
        .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .o_s_we(o_s_we),
        .o_s_cyc(o_s_cyc), .i_s_rdt(i_s_rdt), .i_s_ack(i_s_ack),
        .o_grant(o_grant), .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    // Slave memory model: read data is a fixed scramble of the address.
    function automatic logic [31:0] sdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign i_s_rdt = sdata(o_s_adr);
    assign i_s_ack = (o_s_cyc && slave_lat != NEVER && int'(s_cnt) == slave_lat) || stray;

    // Slave latency counter: cycles spent in the current slave cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) s_cnt <= 8'd0;
        else if (!o_s_cyc || i_s_ack) s_cnt <= 8'd0;
        else s_cnt <= s_cnt + 8'd1;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round robin as described: first requester after 'last' in order 0,1,2.
    function automatic int model_rr(input int last, input logic [2:0] mask);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (mask[c]) return c;
        end
        return 3;
    endfunction

    function automatic exp_t mk_exp(input int w, input int lat, input logic ab);
        exp_t e;
        e.m       = 2'(w);
        e.adr     = m_adr[w];
        e.dat     = (w == 0) ? 32'h0 : m_dat[w];
        e.sel     = (w == 0) ? 4'hF : m_sel[w];
        e.we      = (w == 0) ? 1'b0 : m_we[w];
        e.tmo     = (lat + 1 > TMO);
        e.rdt     = e.tmo ? ERR : sdata(m_adr[w]);
        e.cyc_idx = e.tmo ? TMO : lat + 1;
        e.abort   = ab;
        return e;
    endfunction

    // Monitor: compares the slave request on cycle start and the completion on ack/abort.
    exp_t mon_e;
    logic in_txn = 1'b0, prev_scyc = 1'b0, prev_ack = 1'b0;
    int   busy_idx = 0;
    logic [2:0] acks;
    always @(negedge clk) begin
        acks = {o_m2_ack, o_m1_ack, o_m0_ack};
        if (rst) begin
            if (in_txn && sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("reset_abort_expected", 96'(mon_e.abort), 96'(1));
            end
            in_txn = 1'b0;
            prev_scyc = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (o_s_cyc && !prev_scyc) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cycle", 96'(o_grant), 96'(3));
                end else begin
                    mon_e = sb[0];
                    chk("slave_req", {o_grant, o_s_adr, o_s_dat, o_s_sel, o_s_we},
                        {mon_e.m, mon_e.adr, mon_e.dat, mon_e.sel, mon_e.we});
                    in_txn = 1'b1;
                    busy_idx = 0;
                end
            end
            if (o_s_cyc) busy_idx++;
            if (acks != 3'b000) begin
                if (!in_txn || sb.size() == 0) begin
                    chk("stray_ack", 96'(acks), 96'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_onehot", 96'(acks), 96'(3'b001 << mon_e.m));
                    chk("ack_rdt", 96'(o_m0_rdt | o_m1_rdt | o_m2_rdt), 96'(mon_e.rdt));
                    chk("timeout_err", 96'(o_timeout_err), 96'(mon_e.tmo));
                    chk("ack_cycle", 96'(busy_idx), 96'(mon_e.cyc_idx));
                    chk("ack_not_abort", 96'(mon_e.abort), 96'(0));
                    in_txn = 1'b0;
                end
            end else begin
                chk("timeout_no_ack", 96'(o_timeout_err), 96'(0));
                if (in_txn && !o_s_cyc) begin
                    mon_e = sb.pop_front();
                    chk("abort_expected", 96'(mon_e.abort), 96'(1));
                    in_txn = 1'b0;
                end
            end
            chk("rdt_zero_unacked", {acks[0] ? 32'h0 : o_m0_rdt, acks[1] ? 32'h0 : o_m1_rdt,
                acks[2] ? 32'h0 : o_m2_rdt}, 96'(0));
            if (!o_s_cyc)
                chk("idle_slave_zero", {o_s_adr, o_s_dat, o_s_sel, o_s_we}, 96'(0));
            if (prev_ack)
                chk("gap_after_ack", 96'(o_s_cyc), 96'(0));
            prev_scyc = o_s_cyc;
            prev_ack = (acks != 3'b000);
        end
    end

    // Issue one arbitration round; caller is just after a rising edge with the DUT idle.
    task automatic run_txn(input logic [2:0] mask, input int lat);
        int w;
        bit done;
        w = model_rr(model_last, mask);
        sb.push_back(mk_exp(w, lat, 1'b0));
        slave_lat = lat;
        m_cyc = mask;
        @(negedge clk);
        chk("req_cycle_idle", 96'(o_s_cyc), 96'(0));
        @(negedge clk);
        chk("cyc_next_cycle", 96'(o_s_cyc), 96'(1));
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if ({o_m2_ack, o_m1_ack, o_m0_ack} != 3'b000) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) chk("ack_wait_expired", 96'(0), 96'(1));
        @(posedge clk);
        #1;
        m_cyc = 3'b000;
        model_last = w;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation bound reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            m_adr[i] = $urandom; m_dat[i] = $urandom;
            m_sel[i] = 4'($urandom); m_we[i] = 1'($urandom);
        end
        #3;
        chk("reset_state", {o_grant, o_s_cyc, o_m0_ack, o_m1_ack, o_m2_ack, o_timeout_err},
            {2'd3, 5'b00000});

        // All three masters request continuously out of reset: grants 0,1,2,0.
        m_cyc = 3'b111;
        slave_lat = 0;
        sb.push_back(mk_exp(0, 0, 1'b0));
        sb.push_back(mk_exp(1, 0, 1'b0));
        sb.push_back(mk_exp(2, 0, 1'b0));
        sb.push_back(mk_exp(0, 0, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge clk);
            if ({o_m2_ack, o_m1_ack, o_m0_ack} != 3'b000) n++;
        end
        chk("rr_four_acks", 96'(n), 96'(4));
        @(posedge clk); #1;
        m_cyc = 3'b000;
        model_last = 0;

        // m0 read at 0x100, slave acks one cycle after cyc.
        m_adr[0] = 32'h0000_0100;
        run_txn(3'b001, 1);

        // m1 write.
        m_adr[1] = 32'h0000_8004; m_dat[1] = 32'hCAFE_BABE; m_sel[1] = 4'b0011; m_we[1] = 1'b1;
        run_txn(3'b010, 2);

        // m2 read on a slave that never acks, then m0 must win next.
        m_we[2] = 1'b0;
        run_txn(3'b100, NEVER);
        run_txn(3'b011, 0);

        // Ack coinciding with the timeout cycle is a normal ack.
        run_txn(3'b010, TMO - 1);

        // Ack from the slave while idle is ignored.
        stray = 1'b1;
        @(negedge clk);
        chk("idle_ack_ignored", 96'({o_m2_ack, o_m1_ack, o_m0_ack, o_s_cyc}), 96'(0));
        @(posedge clk); #1;
        stray = 1'b0;

        // m1 drops cyc in its second BUSY cycle.
        sb.push_back(mk_exp(1, NEVER, 1'b1));
        slave_lat = NEVER;
        m_cyc = 3'b010;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy1_cyc", 96'(o_s_cyc), 96'(1));
        @(posedge clk); #1;
        m_cyc = 3'b000;
        @(negedge clk);
        chk("abort_cycle", {o_s_cyc, o_m1_ack, o_grant}, {2'b00, 2'd1});
        @(negedge clk);
        chk("abort_then_idle", 96'(o_grant), 96'(3));
        model_last = 1;
        @(posedge clk); #1;

        // Reset between edges mid-transaction, then m0 wins first.
        sb.push_back(mk_exp(2, NEVER, 1'b1));
        m_cyc = 3'b100;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {o_s_cyc, o_grant, o_m0_ack, o_m1_ack, o_m2_ack, o_timeout_err},
            {1'b0, 2'd3, 4'b0000});
        m_cyc = 3'b000;
        model_last = 2;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(3'b111, 1);

        // Randomised rounds against the round-robin model.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 3; i++) begin
                m_adr[i] = $urandom; m_dat[i] = $urandom;
                m_sel[i] = 4'($urandom); m_we[i] = 1'($urandom);
            end
            run_txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 9)));
        end

        @(negedge clk);
        chk("scoreboard_empty", 96'(sb.size()), 96'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
